// File: rtl/lsu_mem_master_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_master_if
//   Bundles the load/store request/response handshake and the data-memory
//   port of lsu_mem_master.
//
//   Request  : req_valid, req_ready, req_we, req_size, req_unsigned,
//              req_addr, req_wdata
//   Response : resp_valid, resp_rdata, resp_err
//   Memory   : mem_address (word index), mem_dataW, mem_isWmem, mem_dataR
//
//   modport master : the load/store unit itself
//   modport slave  : the requester plus data memory on the other side
// ----------------------------------------------------------------------------
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_address;
  logic [31:0] mem_dataW;
  logic        mem_isWmem;
  logic [31:0] mem_dataR;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_dataR,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_dataW, mem_isWmem
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_dataR,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_dataW, mem_isWmem
  );
endinterface

// File: rtl/lsu_mem_master.sv
// ----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator for a word-wide data memory with combinational read
//   and clock-edge write. Takes one byte/half/word request at a time, turns it
//   into word-aligned accesses (read-modify-write for sub-word stores) and
//   returns sign- or zero-extended load data. Little-endian lanes.
//
//   Ports:
//     clk   : clock, rising edge
//     rstn  : synchronous reset, active HIGH (1 = reset)
//     bus   : lsu_mem_master_if.master (request, response, memory port)
//     stat_loads/stat_stores/stat_errs : completed-response counters,
//                                        present only with LSU_STATS_EN
//
//   Parameter MEM_DEPTH_LOG2 : word-index width; higher address bits ignored.
//   Optional macro LSU_STATS_EN adds the statistics counters.
// ----------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rstn,
  lsu_mem_master_if.master bus
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]      stat_loads,
  output logic [15:0]      stat_stores,
  output logic [15:0]      stat_errs
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        we_reg, we_next;
  logic [1:0]  size_reg, size_next;
  logic        uns_reg, uns_next;
  logic [1:0]  lane_reg, lane_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [31:0] address_reg, address_next;
  logic [31:0] dataw_reg, dataw_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic        req_err;
  logic [31:0] req_index;
  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [3:0]  lane_be;
  logic [31:0] merged;
  logic        unused_addr_bits;

  // Word index; upper address bits fold away so accesses wrap.
  assign req_index        = {{(32-MEM_DEPTH_LOG2){1'b0}}, bus.req_addr[MEM_DEPTH_LOG2+1:2]};
  assign unused_addr_bits = ^bus.req_addr[31:MEM_DEPTH_LOG2+2];

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Load lane extraction from the word currently on mem_dataR.
  assign shifted = bus.mem_dataR >> {lane_reg, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = lane_reg[1] ? bus.mem_dataR[31:16] : bus.mem_dataR[15:0];

  always_comb begin
    load_data = bus.mem_dataR;
    case (size_reg)
      2'b00:   load_data = uns_reg ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = uns_reg ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = bus.mem_dataR;
    endcase
  end

  // Read-modify-write merge: only sub-word stores pass through RD, so the
  // enables only need to cover byte and half sizes.
  assign lane_be = (size_reg == 2'b00) ? (4'b0001 << lane_reg)
                                       : (lane_reg[1] ? 4'b1100 : 4'b0011);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      logic [7:0] src_byte;
      if (gi % 2 == 1) begin : g_odd
        // Odd lanes take the high byte of a halfword, or the sole byte.
        assign src_byte = (size_reg == 2'b00) ? wdata_reg[7:0] : wdata_reg[15:8];
      end else begin : g_even
        assign src_byte = wdata_reg[7:0];
      end
      assign merged[8*gi +: 8] = lane_be[gi] ? src_byte : bus.mem_dataR[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    we_next      = we_reg;
    size_next    = size_reg;
    uns_next     = uns_reg;
    lane_next    = lane_reg;
    wdata_next   = wdata_reg;
    address_next = address_reg;
    dataw_next   = dataw_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          we_next      = bus.req_we;
          size_next    = bus.req_size;
          uns_next     = bus.req_unsigned;
          lane_next    = bus.req_addr[1:0];
          wdata_next   = bus.req_wdata[15:0];
          address_next = req_index;
          rdata_next   = 32'h0;
          err_next     = req_err;
          if (req_err) begin
            state_next = RESP;
          end else if (bus.req_we && bus.req_size == 2'b10) begin
            dataw_next = bus.req_wdata;
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        if (we_reg) begin
          dataw_next = merged;
          state_next = WR;
        end else begin
          rdata_next = load_data;
          state_next = RESP;
        end
      end
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_reg   <= IDLE;
      we_reg      <= 1'b0;
      size_reg    <= 2'b00;
      uns_reg     <= 1'b0;
      lane_reg    <= 2'b00;
      wdata_reg   <= 16'h0;
      address_reg <= 32'h0;
      dataw_reg   <= 32'h0;
      rdata_reg   <= 32'h0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= we_next;
      size_reg    <= size_next;
      uns_reg     <= uns_next;
      lane_reg    <= lane_next;
      wdata_reg   <= wdata_next;
      address_reg <= address_next;
      dataw_reg   <= dataw_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
    end
  end

  assign bus.req_ready   = (state_reg == IDLE);
  assign bus.resp_valid  = (state_reg == RESP);
  assign bus.resp_rdata  = rdata_reg;
  assign bus.resp_err    = err_reg;
  assign bus.mem_address = address_reg;
  assign bus.mem_dataW   = dataw_reg;
  // Reset gates the write so a store caught in WR never reaches memory.
  assign bus.mem_isWmem  = (state_reg == WR) && !rstn;

`ifdef LSU_STATS_EN
  logic [15:0] loads_reg, stores_reg, errs_reg;

  always_ff @(posedge clk) begin
    if (rstn) begin
      loads_reg  <= 16'h0;
      stores_reg <= 16'h0;
      errs_reg   <= 16'h0;
    end else if (state_reg == RESP) begin
      if (err_reg)     errs_reg   <= errs_reg + 16'd1;
      else if (we_reg) stores_reg <= stores_reg + 16'd1;
      else             loads_reg  <= loads_reg + 16'd1;
    end
  end

  assign stat_loads  = loads_reg;
  assign stat_stores = stores_reg;
  assign stat_errs   = errs_reg;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_master
//   Directed bench for lsu_mem_master with a word memory model (combinational
//   read, clock-edge write). Inputs change and outputs are sampled on the
//   falling clock edge.
// ----------------------------------------------------------------------------
module tb_lsu_mem_master;

  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();

`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  lsu_mem_master #(.MEM_DEPTH_LOG2(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef LSU_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // Memory model plus a side door for preloading words.
  logic [31:0] mem [0:255];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_data;

  assign bus.mem_dataR = mem[bus.mem_address[7:0]];

  always @(posedge clk) begin
    if (bus.mem_isWmem === 1'b1) mem[bus.mem_address[7:0]] <= bus.mem_dataW;
    else if (poke_en)            mem[poke_idx] <= poke_data;
  end

  int          wr_count;
  logic [31:0] last_wr_addr;

  always @(posedge clk) begin
    if (bus.mem_isWmem === 1'b1) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= bus.mem_address;
    end
  end

  int vectors;
  int miscompares;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_idx  = idx;
    poke_data = data;
    @(posedge clk);
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue one request from IDLE; returns latency in cycles, response fields
  // and the number of memory writes seen. Ends one cycle after the response.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata,
                       output logic err, output int wrs);
    int wr_before;
    wr_before        = wr_count;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    vectors++;
    if (bus.resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_timeout: resp_valid=%b required 1 within 8 cycles", bus.resp_valid);
    end
    @(negedge clk);
    wrs = wr_count - wr_before;
    $display("txn we=%0d size=%0d uns=%0d addr=%08h wdata=%08h lat=%0d rdata=%08h err=%0d writes=%0d",
             we, size, uns, addr, wdata, lat, rdata, err, wrs);
  endtask

  task automatic test_reset();
    rstn             = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    poke_en          = 1'b0;
    poke_idx         = 8'h0;
    poke_data        = 32'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    vectors += 7;
    if (bus.req_ready !== 1'b1)       begin miscompares++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0)      begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    if (bus.resp_err !== 1'b0)        begin miscompares++; $display("FAIL rst_resp_err: got %b want 0", bus.resp_err); end
    if (bus.resp_rdata !== 32'h0)     begin miscompares++; $display("FAIL rst_rdata: got %08h want 0", bus.resp_rdata); end
    if (bus.mem_address !== 32'h0)    begin miscompares++; $display("FAIL rst_address: got %08h want 0", bus.mem_address); end
    if (bus.mem_dataW !== 32'h0)      begin miscompares++; $display("FAIL rst_dataW: got %08h want 0", bus.mem_dataW); end
    if (bus.mem_isWmem !== 1'b0)      begin miscompares++; $display("FAIL rst_isWmem: got %b want 0", bus.mem_isWmem); end
  endtask

  task automatic test_word();
    int lat, wrs;
    logic [31:0] rdata;
    logic err;
    issue(1'b1, 2'b10, 1'b0, 32'h24, 32'hDEADBEEF, lat, rdata, err, wrs);
    vectors += 6;
    if (lat !== 2)                 begin miscompares++; $display("FAIL sw_latency: got %0d want 2", lat); end
    if (err !== 1'b0)              begin miscompares++; $display("FAIL sw_err: got %b want 0", err); end
    if (rdata !== 32'h0)           begin miscompares++; $display("FAIL sw_rdata: got %08h want 0", rdata); end
    if (wrs !== 1)                 begin miscompares++; $display("FAIL sw_writes: got %0d want 1", wrs); end
    if (last_wr_addr !== 32'd9)    begin miscompares++; $display("FAIL sw_address: got %08h want 9", last_wr_addr); end
    if (mem[9] !== 32'hDEADBEEF)   begin miscompares++; $display("FAIL sw_mem: got %08h want deadbeef", mem[9]); end
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, lat, rdata, err, wrs);
    vectors += 3;
    if (lat !== 2)                 begin miscompares++; $display("FAIL lw_latency: got %0d want 2", lat); end
    if (rdata !== 32'hDEADBEEF)    begin miscompares++; $display("FAIL lw_rdata: got %08h want deadbeef", rdata); end
    if (wrs !== 0)                 begin miscompares++; $display("FAIL lw_writes: got %0d want 0", wrs); end
  endtask

  task automatic test_subword_store();
    vec_t v[4];
    int lat, wrs;
    logic [31:0] rdata;
    logic err;
    // exp = memory word at index 2 after each store
    v[0] = '{1'b1, 2'b00, 1'b0, 32'h09, 32'h000000AA, 32'h1122AA44, 3};
    v[1] = '{1'b1, 2'b01, 1'b0, 32'h0A, 32'h00005566, 32'h5566AA44, 3};
    v[2] = '{1'b1, 2'b01, 1'b0, 32'h08, 32'hFFFFBEEF, 32'h5566BEEF, 3};
    v[3] = '{1'b1, 2'b00, 1'b0, 32'h0B, 32'h00000177, 32'h7766BEEF, 3};
    poke(8'd2, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      issue(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, lat, rdata, err, wrs);
      vectors += 5;
      if (lat !== v[i].lat)        begin miscompares++; $display("FAIL sub_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      if (err !== 1'b0)            begin miscompares++; $display("FAIL sub_err[%0d]: got %b want 0", i, err); end
      if (wrs !== 1)               begin miscompares++; $display("FAIL sub_writes[%0d]: got %0d want 1", i, wrs); end
      if (last_wr_addr !== 32'd2)  begin miscompares++; $display("FAIL sub_address[%0d]: got %08h want 2", i, last_wr_addr); end
      if (mem[2] !== v[i].exp)     begin miscompares++; $display("FAIL sub_mem[%0d]: got %08h want %08h", i, mem[2], v[i].exp); end
    end
  endtask

  task automatic test_load_ext();
    vec_t v[10];
    int lat, wrs;
    logic [31:0] rdata;
    logic err;
    v[0] = '{1'b0, 2'b00, 1'b0, 32'h0C,  32'h0, 32'hFFFFFFFF, 2};
    v[1] = '{1'b0, 2'b00, 1'b1, 32'h0C,  32'h0, 32'h000000FF, 2};
    v[2] = '{1'b0, 2'b01, 1'b0, 32'h0E,  32'h0, 32'hFFFF8000, 2};
    v[3] = '{1'b0, 2'b01, 1'b1, 32'h0E,  32'h0, 32'h00008000, 2};
    v[4] = '{1'b0, 2'b00, 1'b0, 32'h0D,  32'h0, 32'hFFFFFFF0, 2};
    v[5] = '{1'b0, 2'b00, 1'b1, 32'h0E,  32'h0, 32'h00000000, 2};
    v[6] = '{1'b0, 2'b00, 1'b0, 32'h0F,  32'h0, 32'hFFFFFF80, 2};
    v[7] = '{1'b0, 2'b01, 1'b0, 32'h0C,  32'h0, 32'hFFFFF0FF, 2};
    v[8] = '{1'b0, 2'b01, 1'b1, 32'h0C,  32'h0, 32'h0000F0FF, 2};
    v[9] = '{1'b0, 2'b10, 1'b0, 32'h40C, 32'h0, 32'h8000F0FF, 2};
    poke(8'd3, 32'h8000F0FF);
    for (int i = 0; i < 10; i++) begin
      issue(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, lat, rdata, err, wrs);
      vectors += 3;
      if (lat !== v[i].lat)  begin miscompares++; $display("FAIL ld_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      if (rdata !== v[i].exp) begin miscompares++; $display("FAIL ld_rdata[%0d]: got %08h want %08h", i, rdata, v[i].exp); end
      if (err !== 1'b0)      begin miscompares++; $display("FAIL ld_err[%0d]: got %b want 0", i, err); end
    end
  endtask

  task automatic test_errors();
    vec_t v[5];
    int lat, wrs;
    logic [31:0] rdata;
    logic err;
    v[0] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0, 1};
    v[1] = '{1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        32'h0, 1};
    v[2] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0, 1};
    v[3] = '{1'b1, 2'b10, 1'b0, 32'h02, 32'hCAFEF00D, 32'h0, 1};
    v[4] = '{1'b1, 2'b01, 1'b0, 32'h01, 32'h00001234, 32'h0, 1};
    poke(8'd0, 32'h0BADF00D);
    for (int i = 0; i < 5; i++) begin
      issue(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, lat, rdata, err, wrs);
      vectors += 4;
      if (lat !== v[i].lat) begin miscompares++; $display("FAIL err_latency[%0d]: got %0d want 1", i, lat); end
      if (err !== 1'b1)     begin miscompares++; $display("FAIL err_flag[%0d]: got %b want 1", i, err); end
      if (rdata !== 32'h0)  begin miscompares++; $display("FAIL err_rdata[%0d]: got %08h want 0", i, rdata); end
      if (wrs !== 0)        begin miscompares++; $display("FAIL err_writes[%0d]: got %0d want 0", i, wrs); end
    end
    vectors++;
    if (mem[0] !== 32'h0BADF00D) begin miscompares++; $display("FAIL err_mem: got %08h want 0badf00d", mem[0]); end
  endtask

  task automatic test_reset_mid_wr();
    int wr_before;
    poke(8'd4, 32'h12345678);
    wr_before        = wr_count;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'h99;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.mem_isWmem !== 1'b0 && bus.mem_isWmem !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_inwr: isWmem=%b required 1", bus.mem_isWmem);
    end else if (bus.mem_isWmem !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_inwr: isWmem=%b required 1", bus.mem_isWmem);
    end
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors += 6;
    if (bus.mem_isWmem !== 1'b0)   begin miscompares++; $display("FAIL midrst_isWmem: got %b want 0", bus.mem_isWmem); end
    if (bus.req_ready !== 1'b1)    begin miscompares++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0)   begin miscompares++; $display("FAIL midrst_resp_valid: got %b want 0", bus.resp_valid); end
    if (bus.mem_address !== 32'h0) begin miscompares++; $display("FAIL midrst_address: got %08h want 0", bus.mem_address); end
    if (mem[4] !== 32'h12345678)   begin miscompares++; $display("FAIL midrst_mem: got %08h want 12345678", mem[4]); end
    if (wr_count !== wr_before)    begin miscompares++; $display("FAIL midrst_writes: got %0d want 0", wr_count - wr_before); end
    rstn = 1'b0;
    $display("txn reset during WR of sb addr=00000010, mem[4]=%08h", mem[4]);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    vec_t v[6];
    v[0] = '{1'b1, 2'b10, 1'b0, 32'h50, 32'hA5A50000, 32'h0,        2};
    v[1] = '{1'b0, 2'b10, 1'b0, 32'h50, 32'h0,        32'hA5A50000, 2};
    v[2] = '{1'b1, 2'b10, 1'b0, 32'h50, 32'hA5A50002, 32'h0,        2};
    v[3] = '{1'b0, 2'b10, 1'b0, 32'h50, 32'h0,        32'hA5A50002, 2};
    v[4] = '{1'b1, 2'b00, 1'b0, 32'h51, 32'h0000003C, 32'h0,        3};
    v[5] = '{1'b0, 2'b10, 1'b0, 32'h50, 32'h0,        32'hA5A53C02, 2};
    bus.req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_idle[%0d]: got %b want 1", k, bus.req_ready); end
      bus.req_we       = v[k].we;
      bus.req_size     = v[k].size;
      bus.req_unsigned = v[k].uns;
      bus.req_addr     = v[k].addr;
      bus.req_wdata    = v[k].wdata;
      @(posedge clk);
      for (int c = 1; c <= v[k].lat; c++) begin
        @(negedge clk);
        vectors += 2;
        if (bus.req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready_busy[%0d.%0d]: got %b want 0", k, c, bus.req_ready);
        end
        if (bus.resp_valid !== (c == v[k].lat)) begin
          miscompares++;
          $display("FAIL b2b_resp_valid[%0d.%0d]: got %b want %b", k, c, bus.resp_valid, (c == v[k].lat));
        end
        if (c == v[k].lat && !v[k].we) begin
          vectors++;
          if (bus.resp_rdata !== v[k].exp) begin
            miscompares++;
            $display("FAIL b2b_rdata[%0d]: got %08h want %08h", k, bus.resp_rdata, v[k].exp);
          end
        end
      end
      $display("txn b2b we=%0d size=%0d addr=%08h wdata=%08h rdata=%08h",
               v[k].we, v[k].size, v[k].addr, v[k].wdata, bus.resp_rdata);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    wr_count    = 0;
    test_reset();
    test_word();
    test_subword_store();
    test_load_ext();
    test_errors();
    test_reset_mid_wr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
